// File: rtl/vend_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : vend_pkg                                                    |
// | Purpose  : Shared types and constants for the vend result sequencer:   |
// |            FSM state encoding, default parameters, audit width and a   |
// |            saturating-increment helper.                                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package vend_pkg;

  // Sequencer states; 3-bit encoding covers the five states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DISP = 3'd1,
    COIN = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } vend_state_t;

  localparam int N_CH_DEF      = 3;
  localparam int CHG_W_DEF     = 2;
  localparam int PULSE_CYC_DEF = 4;

  // Width of the optional audit counters
  localparam int AUDIT_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [AUDIT_W-1:0] sat_inc(input logic [AUDIT_W-1:0] v);
    return (v == {AUDIT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_result_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface: vend_result_seq_if                                          |
// | Purpose  : Request/acknowledge bundle between the per-price FSMs       |
// |            (master) and the result sequencer (slave).                  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface vend_result_seq_if
  import vend_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CHG_W = CHG_W_DEF
);

  logic [N_CH-1:0]       req_vld;
  logic [N_CH-1:0]       req_prod;
  logic [N_CH*CHG_W-1:0] req_chg;
  logic [N_CH-1:0]       req_ack;

  // Price FSM side: raises a finished transaction, waits for the ack
  modport master (
    output req_vld,
    output req_prod,
    output req_chg,
    input  req_ack
  );

  // Sequencer side: consumes transactions and returns the ack pulse
  modport slave (
    input  req_vld,
    input  req_prod,
    input  req_chg,
    output req_ack
  );

endinterface
`default_nettype wire

// File: rtl/vend_rr_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : vend_rr_arb                                                 |
// | Purpose  : Combinational round-robin pick. Scans req_vld starting at   |
// |            ptr, wrapping N_CH-1 -> 0; returns one-hot grant, binary    |
// |            index of the winner and an any-request flag.                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module vend_rr_arb #(
  parameter int N_CH  = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  req_vld,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_vld
);

  logic             w_found;
  logic [IDX_W-1:0] w_pos;

  // Channel index at offset 'off' from 'base', wrapped into 0..N_CH-1
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return IDX_W'(s);
  endfunction

  assign any_vld = |req_vld;

  // First requesting channel at or after the pointer wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_pos = wrap_add(ptr, i);
      if (!w_found && req_vld[w_pos]) begin
        w_found       = 1'b1;
        grant[w_pos]  = 1'b1;
        grant_idx     = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vend_result_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : vend_result_seq                                             |
// | Purpose  : Round-robin merge of finished vend transactions from N_CH   |
// |            price FSMs. Emits one product pulse (z) then one change     |
// |            pulse (c) per coin, each PULSE_CYC wide with PULSE_CYC      |
// |            gaps, and a one-cycle ack to the served channel.            |
// |            Optional: define VEND_AUDIT_EN to add saturating 16-bit     |
// |            vend_cnt / coin_cnt outputs.                                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module vend_result_seq
  import vend_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int CHG_W     = CHG_W_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  vend_result_seq_if.slave    req,
  output logic                z,
  output logic                c,
  output logic                busy
`ifdef VEND_AUDIT_EN
  ,
  output logic [AUDIT_W-1:0]  vend_cnt,
  output logic [AUDIT_W-1:0]  coin_cnt
`endif
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PH_W  = $clog2(PULSE_CYC + 1);
  // Phase counter counts down to zero, so a load of PULSE_CYC-1 gives PULSE_CYC cycles
  localparam logic [PH_W-1:0]  C_PH_LOAD = PH_W'(PULSE_CYC - 1);
  localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(N_CH - 1);

  vend_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [CHG_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic [N_CH-1:0]   r_ack, w_ack_nxt;
  logic              r_z, r_c, r_busy;

  logic [N_CH-1:0]   w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_any;
  logic              w_win_prod;
  logic [CHG_W-1:0]  w_win_chg;

  vend_rr_arb #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_vld   (req.req_vld),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any_vld   (w_any)
  );

  assign w_win_prod = req.req_prod[w_gidx];
  assign w_win_chg  = req.req_chg[w_gidx*CHG_W +: CHG_W];

  // Next-state, pointer, coin count and phase; arbitration only happens in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_ack_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ack_nxt   = w_grant;
          w_ptr_nxt   = (w_gidx == C_IDX_MAX) ? '0 : w_gidx + 1'b1;
          w_cnt_nxt   = w_win_chg;
          w_phase_nxt = C_PH_LOAD;
          if (w_win_prod)
            w_state_nxt = DISP;
          else if (w_win_chg != '0)
            w_state_nxt = COIN;
          else
            w_state_nxt = DONE;
        end
      end
      DISP: begin
        if (r_phase == '0) begin
          w_state_nxt = GAP;
          w_phase_nxt = C_PH_LOAD;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      COIN: begin
        if (r_phase == '0) begin
          w_state_nxt = GAP;
          w_phase_nxt = C_PH_LOAD;
          w_cnt_nxt   = r_cnt - 1'b1;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      GAP: begin
        if (r_phase == '0) begin
          w_phase_nxt = C_PH_LOAD;
          w_state_nxt = (r_cnt != '0) ? COIN : DONE;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next state so pulses line up with ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_ack   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_ack   <= w_ack_nxt;
      r_z     <= (w_state_nxt == DISP);
      r_c     <= (w_state_nxt == COIN);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign z           = r_z;
  assign c           = r_c;
  assign busy        = r_busy;
  assign req.req_ack = r_ack;

`ifdef VEND_AUDIT_EN
  logic [AUDIT_W-1:0] r_vend_cnt, r_coin_cnt;

  // Count entries into DISP and COIN, sticking at full scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vend_cnt <= '0;
      r_coin_cnt <= '0;
    end else begin
      if (w_state_nxt == DISP && r_state != DISP)
        r_vend_cnt <= sat_inc(r_vend_cnt);
      if (w_state_nxt == COIN && r_state != COIN)
        r_coin_cnt <= sat_inc(r_coin_cnt);
    end
  end

  assign vend_cnt = r_vend_cnt;
  assign coin_cnt = r_coin_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vend_result_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_vend_result_seq                                          |
// | Purpose  : Directed self-checking bench for vend_result_seq with       |
// |            default parameters (3 channels, 2-bit change, 4-cycle       |
// |            pulses). Audit counters are checked when VEND_AUDIT_EN set. |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_vend_result_seq;
  import vend_pkg::*;

  localparam int N_CH  = 3;
  localparam int CHG_W = 2;

  logic clk;
  logic rst_n;
  logic z, c, busy;
`ifdef VEND_AUDIT_EN
  logic [AUDIT_W-1:0] vend_cnt, coin_cnt;
`endif

  vend_result_seq_if #(.N_CH(N_CH), .CHG_W(CHG_W)) req_if ();

  vend_result_seq #(
    .N_CH      (N_CH),
    .CHG_W     (CHG_W),
    .PULSE_CYC (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_if),
    .z        (z),
    .c        (c),
    .busy     (busy)
`ifdef VEND_AUDIT_EN
    ,
    .vend_cnt (vend_cnt),
    .coin_cnt (coin_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Activity observed since the last clear_mon
  int   n_z_cyc, n_c_cyc, n_c_pulse, n_busy_cyc, n_overlap, n_bad_ack;
  int   ack_q[$];
  logic c_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: run still active at 100us, expected finish well before");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_z_cyc = 0; n_c_cyc = 0; n_c_pulse = 0; n_busy_cyc = 0;
    n_overlap = 0; n_bad_ack = 0;
    ack_q.delete();
  endtask

  // One clock; sample 1ns after the edge and act as the requesters (drop vld on ack)
  task automatic tick();
    @(posedge clk);
    #1;
    if (z) n_z_cyc++;
    if (c) n_c_cyc++;
    if (c && !c_prev) n_c_pulse++;
    c_prev = c;
    if (busy) n_busy_cyc++;
    if (z && c) n_overlap++;
    if (req_if.req_ack != '0) begin
      if ($countones(req_if.req_ack) != 1) n_bad_ack++;
      for (int i = 0; i < N_CH; i++)
        if (req_if.req_ack[i]) ack_q.push_back(i);
      req_if.req_vld = req_if.req_vld & ~req_if.req_ack;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int ch, input logic prod, input logic [CHG_W-1:0] chg);
    req_if.req_vld[ch]            = 1'b1;
    req_if.req_prod[ch]           = prod;
    req_if.req_chg[ch*CHG_W +: CHG_W] = chg;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_if.req_vld  = '0;
    req_if.req_prod = '0;
    req_if.req_chg  = '0;
    run(3);
    rst_n = 1'b1;
  endtask

  function automatic int ack_at(input int idx);
    return (idx < ack_q.size()) ? ack_q[idx] : -1;
  endfunction

  initial begin
    int e_z, e_c, e_b, e_a;
    c_prev = 1'b0;
    clear_mon();
    apply_reset();

    // Reset state
    check_val("rst_z",    32'(z),              32'd0);
    check_val("rst_c",    32'(c),              32'd0);
    check_val("rst_busy", 32'(busy),           32'd0);
    check_val("rst_ack",  32'(req_if.req_ack), 32'd0);
`ifdef VEND_AUDIT_EN
    check_val("rst_vend_cnt", 32'(vend_cnt), 32'd0);
    check_val("rst_coin_cnt", 32'(coin_cnt), 32'd0);
`endif

    // ch1 prod=1 chg=2: cycle-exact waveform over 27 cycles
    set_req(1, 1'b1, 2'd2);
    for (int k = 1; k <= 27; k++) begin
      tick();
      e_z = (k >= 1 && k <= 4) ? 1 : 0;
      e_c = ((k >= 9 && k <= 12) || (k >= 17 && k <= 20)) ? 1 : 0;
      e_b = (k <= 25) ? 1 : 0;
      e_a = (k == 1) ? 2 : 0;
      check_val($sformatf("t1_z[%0d]", k),    32'(z),              32'(e_z));
      check_val($sformatf("t1_c[%0d]", k),    32'(c),              32'(e_c));
      check_val($sformatf("t1_busy[%0d]", k), 32'(busy),           32'(e_b));
      check_val($sformatf("t1_ack[%0d]", k),  32'(req_if.req_ack), 32'(e_a));
    end

    // All three channels at once from reset: served 0, 1, 2
    apply_reset();
    clear_mon();
    set_req(0, 1'b0, 2'd0);
    set_req(1, 1'b0, 2'd1);
    set_req(2, 1'b0, 2'd0);
    run(40);
    check_val("t2_nack",   32'(ack_q.size()), 32'd3);
    check_val("t2_ord0",   32'(ack_at(0)),    32'd0);
    check_val("t2_ord1",   32'(ack_at(1)),    32'd1);
    check_val("t2_ord2",   32'(ack_at(2)),    32'd2);
    check_val("t2_cpulse", 32'(n_c_pulse),    32'd1);
    check_val("t2_busy",   32'(n_busy_cyc),   32'd11);

    // Pointer wrapped to 0: ch0 then ch2
    clear_mon();
    set_req(0, 1'b1, 2'd0);
    set_req(2, 1'b0, 2'd0);
    run(30);
    check_val("t2b_nack", 32'(ack_q.size()), 32'd2);
    check_val("t2b_ord0", 32'(ack_at(0)),    32'd0);
    check_val("t2b_ord1", 32'(ack_at(1)),    32'd2);
    check_val("t2b_zcyc", 32'(n_z_cyc),      32'd4);
    check_val("t2b_busy", 32'(n_busy_cyc),   32'd10);

    // Empty transaction on ch2: acked, one busy cycle, no pulses
    clear_mon();
    set_req(2, 1'b0, 2'd0);
    run(6);
    check_val("t3_nack", 32'(ack_q.size()), 32'd1);
    check_val("t3_ch",   32'(ack_at(0)),    32'd2);
    check_val("t3_busy", 32'(n_busy_cyc),   32'd1);
    check_val("t3_zcyc", 32'(n_z_cyc),      32'd0);
    check_val("t3_ccyc", 32'(n_c_cyc),      32'd0);

    // Max change on ch0: three coin pulses, no product
    clear_mon();
    set_req(0, 1'b0, 2'd3);
    run(30);
    check_val("t4_ch",     32'(ack_at(0)),  32'd0);
    check_val("t4_zcyc",   32'(n_z_cyc),    32'd0);
    check_val("t4_cpulse", 32'(n_c_pulse),  32'd3);
    check_val("t4_ccyc",   32'(n_c_cyc),    32'd12);
    check_val("t4_busy",   32'(n_busy_cyc), 32'd25);

    // Reset during second coin pulse (pointer is 1 afterwards if not cleared)
    clear_mon();
    set_req(0, 1'b0, 2'd2);
    run(10);
    check_val("t5_c_before", 32'(c), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_c_async",    32'(c),    32'd0);
    check_val("t5_busy_async", 32'(busy), 32'd0);
    check_val("t5_z_async",    32'(z),    32'd0);
    run(2);
    rst_n = 1'b1;
    clear_mon();
    run(20);
    check_val("t5_idle_busy", 32'(n_busy_cyc),   32'd0);
    check_val("t5_idle_c",    32'(n_c_cyc),      32'd0);
    check_val("t5_idle_ack",  32'(ack_q.size()), 32'd0);
    clear_mon();
    set_req(1, 1'b0, 2'd0);
    set_req(0, 1'b0, 2'd0);
    run(10);
    check_val("t5_ord0", 32'(ack_at(0)), 32'd0);
    check_val("t5_ord1", 32'(ack_at(1)), 32'd1);

`ifdef VEND_AUDIT_EN
    // Audit: (1,1), (1,3), (0,2) -> two dispenses, six coins
    apply_reset();
    clear_mon();
    set_req(0, 1'b1, 2'd1);
    set_req(1, 1'b1, 2'd3);
    set_req(2, 1'b0, 2'd2);
    run(90);
    check_val("t6_vend_cnt", 32'(vend_cnt), 32'd2);
    check_val("t6_coin_cnt", 32'(coin_cnt), 32'd6);
`endif

    check_val("all_overlap", 32'(n_overlap), 32'd0);
    check_val("all_bad_ack", 32'(n_bad_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
